synth_reg_arbiter: RTL and testbench
====================================

Name: synth_reg_arbiter

Overview:
- Owns the synth core's 35-byte register file (`regs[0:34]`) and arbitrates writes from two requesters into a shadow copy.
  - Port A: host bus bridge.
  - Port B: pattern playback engine.
- Commits shadow to live registers atomically, aligned to an audio sample boundary. Channels therefore never see a half-updated parameter set.
- Sits between the bus/playback logic and `synth_core`'s `regs` input.

Parameters:
- NUM_REGS, 35, number of 8-bit synth registers (live and shadow).
- ADDR_W, 6, register address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk_50mhz  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-cycle pulse per audio sample, already in clk_50mhz domain
- a_valid  input  1  port A write request
- a_addr  input  ADDR_W  port A register address
- a_data  input  8  port A write data
- a_ready  output  1  port A write accepted this cycle
- b_valid  input  1  port B write request
- b_addr  input  ADDR_W  port B register address
- b_data  input  8  port B write data
- b_ready  output  1  port B write accepted this cycle
- commit_req  input  1  request shadow-to-live copy
- commit_busy  output  1  commit pending
- commit_done  output  1  one-cycle pulse after live registers update
- addr_err  output  1  one-cycle pulse: accepted write had addr >= NUM_REGS
- rd_addr  input  ADDR_W  shadow readback address
- rd_data  output  8  shadow readback data, 1-cycle latency
- regs  output  8 x NUM_REGS (unpacked [0:NUM_REGS-1])  live registers to synth_core

Behaviour:
- **Reset (async, reset_n low):**
  - Shadow and live = 0; state = IDLE; last_grant = B, so A wins first contention.
  - commit_busy, commit_done, addr_err, rd_data = 0.
  - Reset mid-commit aborts the commit; no partial copy.
- **States:**
  - IDLE: writes allowed; commit_busy = 0.
  - WAIT_TICK: writes stalled; commit_busy = 1.
- **Arbitration (combinational ready, IDLE only):**
  - Only one valid: that port gets ready.
  - Both valid: grant goes to the port opposite last_grant; last_grant updates to the granted port.
  - In WAIT_TICK: a_ready = b_ready = 0. Requesters must hold valid, addr and data until ready.
  - At most one write accepted per cycle.
- **Write:**
  - An accepted write with addr < NUM_REGS updates shadow[addr] at the same edge.
  - addr >= NUM_REGS: accepted (ready = 1), dropped, addr_err = 1 on the next cycle.
- **Commit:**
  - commit_req = 1 in IDLE moves the state to WAIT_TICK next cycle.
  - A write accepted in that same cycle is included in the snapshot.
  - In WAIT_TICK, the first sample_tick copies all shadow to live at that edge, commit_done = 1 for the following cycle, state returns to IDLE.
  - A sample_tick coincident with commit_req in IDLE is not used; the commit waits for the next tick.
  - commit_req while in WAIT_TICK is ignored (coalesced).
  - commit_req held high re-triggers a new commit on each return to IDLE.
- **Readback:** rd_data <= shadow[rd_addr] each cycle; rd_addr >= NUM_REGS returns 0.
- **Live registers:** change only on a commit edge; they are otherwise stable for any write activity.

Test Plan:
- Reset, then A writes addr 3 = 0x5A, then rd_addr = 3 -> rd_data = 0x5A; regs[3] stays 0 until commit.
- A and B both valid for 4 cycles with distinct addrs -> grants A,B,A,B; exactly one ready per cycle.
- commit_req pulse, no tick for 10 cycles -> commit_busy = 1, both readies 0. Tick at cycle 11 -> all regs equal shadow; commit_done pulses one cycle later; busy clears.
- commit_req and sample_tick in the same IDLE cycle -> no copy on that tick; copy occurs on the next tick.
- B writes addr 40 = 0xFF -> b_ready = 1, addr_err pulses, shadow unchanged.
- Deassert reset_n during WAIT_TICK, then release -> regs all 0, state IDLE, no commit_done.

Source files
------------

// File: rtl/synth_reg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : synth_reg_arbiter_if
// Brief    : Write/commit/readback bundle between requesters and the arbiter.
// Revision : 1.0
// ============================================================================
interface synth_reg_arbiter_if #(
  parameter int ADDR_W = 6
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [7:0]        a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        b_data;
  logic              b_ready;
  logic              commit_req;
  logic              commit_busy;
  logic              commit_done;
  logic              addr_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, commit_req, rd_addr,
    input  a_ready, b_ready, commit_busy, commit_done, addr_err, rd_data
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, commit_req, rd_addr,
    output a_ready, b_ready, commit_busy, commit_done, addr_err, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/synth_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : synth_reg_arbiter
// Brief    : Two-port shadow register file with sample-aligned atomic commit.
// Revision : 1.0
// ============================================================================
module synth_reg_arbiter #(
  parameter int NUM_REGS = 35,
  parameter int ADDR_W   = 6
) (
  input  logic                clk_50mhz,
  input  logic                reset_n,
  input  logic                sample_tick,
  synth_reg_arbiter_if.slave  bus,
  output logic [7:0]          regs [0:NUM_REGS-1]
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_TICK = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] c_num_regs = (ADDR_W+1)'(NUM_REGS);

  state_t            r_state;
  logic              r_last_grant_b;
  logic [7:0]        r_shadow [0:NUM_REGS-1];
  logic [7:0]        r_live   [0:NUM_REGS-1];
  logic              r_commit_done;
  logic              r_addr_err;
  logic [7:0]        r_rd_data;

  logic              w_idle;
  logic              w_contend;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_wr_en;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_wr_data;

  // Round-robin only matters under contention; a lone requester always wins.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_contend     = bus.a_valid & bus.b_valid;
  assign w_grant_a     = w_idle & bus.a_valid & (~bus.b_valid | r_last_grant_b);
  assign w_grant_b     = w_idle & bus.b_valid & (~bus.a_valid | ~r_last_grant_b);
  assign w_wr_en       = w_grant_a | w_grant_b;
  assign w_wr_addr     = w_grant_a ? bus.a_addr : bus.b_addr;
  assign w_wr_data     = w_grant_a ? bus.a_data : bus.b_data;
  assign w_wr_in_range = ({1'b0, w_wr_addr} < c_num_regs);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_num_regs);

  assign bus.a_ready     = w_grant_a;
  assign bus.b_ready     = w_grant_b;
  assign bus.commit_busy = ~w_idle;
  assign bus.commit_done = r_commit_done;
  assign bus.addr_err    = r_addr_err;
  assign bus.rd_data     = r_rd_data;
  assign regs            = r_live;

  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_last_grant_b <= 1'b1;
      r_commit_done  <= 1'b0;
      r_addr_err     <= 1'b0;
      r_rd_data      <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      r_commit_done <= 1'b0;
      r_addr_err    <= w_wr_en & ~w_wr_in_range;
      r_rd_data     <= w_rd_in_range ? r_shadow[bus.rd_addr] : 8'h00;

      if (w_wr_en && w_wr_in_range) begin
        r_shadow[w_wr_addr] <= w_wr_data;
      end
      if (w_idle && w_contend) begin
        r_last_grant_b <= w_grant_b;
      end

      // Writes are stalled while waiting, so the shadow is frozen at the copy edge.
      case (r_state)
        ST_IDLE: begin
          if (bus.commit_req) begin
            r_state <= ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (sample_tick) begin
            r_live        <= r_shadow;
            r_commit_done <= 1'b1;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_synth_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_synth_reg_arbiter
// Brief    : Directed plus randomized bench against a behavioural register model.
// Revision : 1.0
// ============================================================================
module tb_synth_reg_arbiter;
  localparam int NUM_REGS = 35;
  localparam int ADDR_W   = 6;

  logic       clk_50mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       sample_tick = 1'b0;
  logic [7:0] regs [0:NUM_REGS-1];

  synth_reg_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  synth_reg_arbiter #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk_50mhz   (clk_50mhz),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .bus         (bus),
    .regs        (regs)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the register file
  logic [7:0] m_shadow [0:NUM_REGS-1];
  logic [7:0] m_live   [0:NUM_REGS-1];
  bit         m_busy, m_last_b, m_done, m_err, m_acc_a, m_acc_b;
  logic [7:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) begin
      m_shadow[i] = 8'h00;
      m_live[i]   = 8'h00;
    end
    m_busy = 0; m_last_b = 1; m_done = 0; m_err = 0; m_rd = 8'h00;
    m_acc_a = 0; m_acc_b = 0;
  endtask

  task automatic model_step();
    int         g;
    int         addr;
    logic [7:0] data;
    logic [7:0] rd_new;
    g = 0;
    if (!m_busy) begin
      if (bus.a_valid && bus.b_valid) begin
        g = m_last_b ? 1 : 2;
        m_last_b = (g == 2);
      end else if (bus.a_valid) g = 1;
      else if (bus.b_valid) g = 2;
    end
    rd_new = 8'h00;
    if (int'(bus.rd_addr) < NUM_REGS) rd_new = m_shadow[bus.rd_addr];
    m_acc_a = (g == 1);
    m_acc_b = (g == 2);
    m_err = 0;
    if (g != 0) begin
      addr = (g == 1) ? int'(bus.a_addr) : int'(bus.b_addr);
      data = (g == 1) ? bus.a_data : bus.b_data;
      if (addr < NUM_REGS) m_shadow[addr] = data;
      else m_err = 1;
    end
    m_rd = rd_new;
    m_done = 0;
    if (!m_busy) begin
      m_busy = bus.commit_req;
    end else if (sample_tick) begin
      m_live = m_shadow;
      m_done = 1;
      m_busy = 0;
    end
  endtask

  task automatic check_comb();
    bit ea, eb;
    ea = !m_busy && bus.a_valid && (!bus.b_valid || m_last_b);
    eb = !m_busy && bus.b_valid && (!bus.a_valid || !m_last_b);
    chk("a_ready", bus.a_ready, ea);
    chk("b_ready", bus.b_ready, eb);
  endtask

  task automatic check_regd();
    int mi;
    chk("commit_busy", bus.commit_busy, m_busy);
    chk("commit_done", bus.commit_done, m_done);
    chk("addr_err", bus.addr_err, m_err);
    chk("rd_data", bus.rd_data, m_rd);
    mi = -1;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (regs[i] !== m_live[i]) mi = i;
    total++;
    if (mi >= 0) begin
      bad++;
      $display("FAIL regs[%0d]: got 0x%0h want 0x%0h at %0t", mi, regs[mi], m_live[mi], $time);
    end
  endtask

  // Inputs are set at a falling edge before these are called.
  task automatic settle();
    #1;
    check_comb();
  endtask

  task automatic clock();
    @(posedge clk_50mhz);
    model_step();
    @(negedge clk_50mhz);
    check_regd();
  endtask

  task automatic run_cycle();
    settle();
    clock();
  endtask

  initial begin
    bus.a_valid = 0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_addr = '0; bus.b_data = '0;
    bus.commit_req = 0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk_50mhz);
    reset_n = 1'b1;

    chk("rst_busy", bus.commit_busy, 0);
    chk("rst_done", bus.commit_done, 0);
    chk("rst_rd", bus.rd_data, 0);
    chk("rst_regs34", regs[34], 0);
    check_regd();

    // Single A write, then readback while live stays untouched
    bus.a_valid = 1; bus.a_addr = 6'd3; bus.a_data = 8'h5A;
    settle();
    chk("t1_a_ready", bus.a_ready, 1);
    clock();
    bus.a_valid = 0; bus.rd_addr = 6'd3;
    run_cycle();
    chk("t1_rd", bus.rd_data, 8'h5A);
    chk("t1_live3", regs[3], 8'h00);

    // Contention alternates A,B,A,B
    bus.a_valid = 1; bus.a_addr = 6'd5;  bus.a_data = 8'h10;
    bus.b_valid = 1; bus.b_addr = 6'd10; bus.b_data = 8'h20;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("t2_a_grant", bus.a_ready, (k % 2) == 0);
      chk("t2_b_grant", bus.b_ready, (k % 2) == 1);
      clock();
      if (m_acc_a) begin bus.a_addr++; bus.a_data++; end
      if (m_acc_b) begin bus.b_addr++; bus.b_data++; end
    end
    bus.a_valid = 0; bus.b_valid = 0;

    // Commit with a same-cycle write, then a long wait for the tick
    bus.commit_req = 1; bus.a_valid = 1; bus.a_addr = 6'd20; bus.a_data = 8'h33;
    run_cycle();
    bus.commit_req = 0; bus.a_addr = 6'd21; bus.a_data = 8'h44;
    bus.b_valid = 1; bus.b_addr = 6'd22; bus.b_data = 8'h55;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("t3_busy", bus.commit_busy, 1);
      chk("t3_a_stall", bus.a_ready, 0);
      chk("t3_b_stall", bus.b_ready, 0);
      clock();
    end
    sample_tick = 1;
    run_cycle();
    sample_tick = 0;
    chk("t3_done", bus.commit_done, 1);
    chk("t3_busy_clr", bus.commit_busy, 0);
    chk("t3_live20", regs[20], 8'h33);
    chk("t3_live3", regs[3], 8'h5A);
    chk("t3_live21", regs[21], 8'h00);
    for (int k = 0; k < 2; k++) begin
      run_cycle();
      if (m_acc_a) bus.a_valid = 0;
      if (m_acc_b) bus.b_valid = 0;
    end
    bus.a_valid = 0; bus.b_valid = 0;

    // Tick coincident with commit_req in idle is not used
    bus.a_valid = 1; bus.a_addr = 6'd0; bus.a_data = 8'h11;
    run_cycle();
    bus.a_valid = 0; bus.commit_req = 1; sample_tick = 1;
    run_cycle();
    bus.commit_req = 0; sample_tick = 0;
    chk("t4_busy", bus.commit_busy, 1);
    chk("t4_live0_hold", regs[0], 8'h00);
    chk("t4_no_done", bus.commit_done, 0);
    run_cycle();
    run_cycle();
    sample_tick = 1;
    run_cycle();
    sample_tick = 0;
    chk("t4_live0", regs[0], 8'h11);
    chk("t4_done", bus.commit_done, 1);

    // Out-of-range write from B
    bus.b_valid = 1; bus.b_addr = 6'd40; bus.b_data = 8'hFF; bus.rd_addr = 6'd40;
    settle();
    chk("t5_b_ready", bus.b_ready, 1);
    clock();
    bus.b_valid = 0;
    chk("t5_err", bus.addr_err, 1);
    chk("t5_rd_oor", bus.rd_data, 8'h00);
    run_cycle();
    chk("t5_err_clr", bus.addr_err, 0);

    // Reset while waiting for the tick aborts the commit
    bus.commit_req = 1;
    run_cycle();
    bus.commit_req = 0;
    run_cycle();
    reset_n = 1'b0;
    #1;
    chk("t6_live3", regs[3], 8'h00);
    chk("t6_busy", bus.commit_busy, 0);
    model_reset();
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    reset_n = 1'b1;
    sample_tick = 1;
    run_cycle();
    sample_tick = 0;
    chk("t6_no_done", bus.commit_done, 0);
    chk("t6_live20", regs[20], 8'h00);

    // Randomized traffic; stalled requesters hold their request
    for (int n = 0; n < 3000; n++) begin
      if (!(bus.a_valid && !m_acc_a)) begin
        bus.a_valid = 1'($urandom_range(0, 1));
        bus.a_addr  = 6'($urandom_range(0, 45));
        bus.a_data  = 8'($urandom);
      end
      if (!(bus.b_valid && !m_acc_b)) begin
        bus.b_valid = 1'($urandom_range(0, 1));
        bus.b_addr  = 6'($urandom_range(0, 45));
        bus.b_data  = 8'($urandom);
      end
      bus.commit_req = ($urandom_range(0, 7) == 0);
      sample_tick    = ($urandom_range(0, 5) == 0);
      bus.rd_addr    = 6'($urandom_range(0, 47));
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
